// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   Sequences PC redirection for the pipelined RV32I core. The EX-stage
//   branch/jump outcome and target are turned into registered PC-select,
//   target and flush signals. A misaligned target raises an
//   instruction-address-misaligned trap that is held until acknowledged.
//   Fetch policy is static not-taken, so every taken branch/jump costs one
//   redirect cycle.
//
// Ports
//   i_clk, i_rst         clock (rising edge), async active-high reset
//   i_stall              hazard stall; EX is not resolved while high
//   i_ex_valid           EX holds a real instruction
//   i_ex_branch/jump     EX instruction is a conditional branch / JAL(R)
//   i_ex_cond            branch condition result
//   i_ex_target          computed next PC
//   i_trap_ack           trap handler accepted the misalign exception
//   o_pc_sel/o_pc_target fetch redirect select and target
//   o_flush_if/id/ex     squash IF/ID, ID/EX, EX/MEM registers
//   o_misalign_exc       misalign trap pending
//   o_bad_addr           faulting target (mtval)
//
// Optional feature macro: BRANCH_PERF_EN
//   Adds o_cnt_branch, o_cnt_taken, o_cnt_trap performance counters.

module branch_redirect_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_ex_valid,
  input  logic             i_ex_branch,
  input  logic             i_ex_jump,
  input  logic             i_ex_cond,
  input  logic [WIDTH-1:0] i_ex_target,
  input  logic             i_trap_ack,
  output logic             o_pc_sel,
  output logic [WIDTH-1:0] o_pc_target,
  output logic             o_flush_if,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic             o_misalign_exc,
  output logic [WIDTH-1:0] o_bad_addr
`ifdef BRANCH_PERF_EN
  ,
  output logic [WIDTH-1:0] o_cnt_branch,
  output logic [WIDTH-1:0] o_cnt_taken,
  output logic [WIDTH-1:0] o_cnt_trap
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    TRAP     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             pc_sel_q, pc_sel_d;
  logic [WIDTH-1:0] pc_target_q, pc_target_d;
  logic             flush_if_q, flush_if_d;
  logic             flush_id_q, flush_id_d;
  logic             flush_ex_q, flush_ex_d;
  logic             exc_q, exc_d;
  logic [WIDTH-1:0] bad_addr_q, bad_addr_d;

  logic resolve;
  logic take;
  logic misal;

  assign resolve = i_ex_valid & ~i_stall;
  assign take    = resolve & (i_ex_jump | (i_ex_branch & i_ex_cond));
  // Bit 0 should already be clear from the adder; an odd target is
  // misaligned as well, so either low bit raises the trap.
  assign misal   = i_ex_target[1] | i_ex_target[0];

  always_comb begin
    state_d     = state_q;
    pc_sel_d    = 1'b0;
    pc_target_d = pc_target_q;
    flush_if_d  = 1'b0;
    flush_id_d  = 1'b0;
    flush_ex_d  = 1'b0;
    exc_d       = 1'b0;
    bad_addr_d  = bad_addr_q;
    unique case (state_q)
      IDLE: begin
        if (take && !misal) begin
          state_d     = REDIRECT;
          pc_sel_d    = 1'b1;
          pc_target_d = i_ex_target;
          flush_if_d  = 1'b1;
          flush_id_d  = 1'b1;
          flush_ex_d  = 1'b1;
        end else if (take && misal) begin
          state_d    = TRAP;
          exc_d      = 1'b1;
          bad_addr_d = i_ex_target;
          flush_if_d = 1'b1;
          flush_id_d = 1'b1;
          flush_ex_d = 1'b1;
        end
      end
      // EX content in this cycle is wrong-path; stall does not extend it.
      REDIRECT: state_d = IDLE;
      TRAP: begin
        if (i_trap_ack) begin
          state_d = IDLE;
        end else begin
          exc_d      = 1'b1;
          flush_if_d = 1'b1;
          flush_id_d = 1'b1;
          flush_ex_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      pc_sel_q    <= 1'b0;
      pc_target_q <= '0;
      flush_if_q  <= 1'b0;
      flush_id_q  <= 1'b0;
      flush_ex_q  <= 1'b0;
      exc_q       <= 1'b0;
      bad_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_sel_q    <= pc_sel_d;
      pc_target_q <= pc_target_d;
      flush_if_q  <= flush_if_d;
      flush_id_q  <= flush_id_d;
      flush_ex_q  <= flush_ex_d;
      exc_q       <= exc_d;
      bad_addr_q  <= bad_addr_d;
    end
  end

  assign o_pc_sel       = pc_sel_q;
  assign o_pc_target    = pc_target_q;
  assign o_flush_if     = flush_if_q;
  assign o_flush_id     = flush_id_q;
  assign o_flush_ex     = flush_ex_q;
  assign o_misalign_exc = exc_q;
  assign o_bad_addr     = bad_addr_q;

`ifdef BRANCH_PERF_EN
  logic [WIDTH-1:0] cnt_branch_q, cnt_taken_q, cnt_trap_q;
  logic             count_en;

  assign count_en = (state_q == IDLE) & resolve;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
      cnt_trap_q   <= '0;
    end else if (count_en) begin
      if (i_ex_branch || i_ex_jump) cnt_branch_q <= cnt_branch_q + WIDTH'(1);
      if (take && !misal)           cnt_taken_q  <= cnt_taken_q + WIDTH'(1);
      if (take && misal)            cnt_trap_q   <= cnt_trap_q + WIDTH'(1);
    end
  end

  assign o_cnt_branch = cnt_branch_q;
  assign o_cnt_taken  = cnt_taken_q;
  assign o_cnt_trap   = cnt_trap_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Testbench for branch_redirect_ctrl: drives one EX resolution per cycle,
// pushes the expected registered outputs to a scoreboard queue and compares
// them one cycle later. Build with BRANCH_PERF_EN to also check counters.

module tb_branch_redirect_ctrl;

  localparam int unsigned W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_stall, i_ex_valid, i_ex_branch, i_ex_jump, i_ex_cond;
  logic [W-1:0] i_ex_target;
  logic         i_trap_ack;
  logic         o_pc_sel, o_flush_if, o_flush_id, o_flush_ex, o_misalign_exc;
  logic [W-1:0] o_pc_target, o_bad_addr;
`ifdef BRANCH_PERF_EN
  logic [W-1:0] o_cnt_branch, o_cnt_taken, o_cnt_trap;
`endif

  branch_redirect_ctrl #(.WIDTH(W)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_stall        (i_stall),
    .i_ex_valid     (i_ex_valid),
    .i_ex_branch    (i_ex_branch),
    .i_ex_jump      (i_ex_jump),
    .i_ex_cond      (i_ex_cond),
    .i_ex_target    (i_ex_target),
    .i_trap_ack     (i_trap_ack),
    .o_pc_sel       (o_pc_sel),
    .o_pc_target    (o_pc_target),
    .o_flush_if     (o_flush_if),
    .o_flush_id     (o_flush_id),
    .o_flush_ex     (o_flush_ex),
    .o_misalign_exc (o_misalign_exc),
    .o_bad_addr     (o_bad_addr)
`ifdef BRANCH_PERF_EN
    ,
    .o_cnt_branch   (o_cnt_branch),
    .o_cnt_taken    (o_cnt_taken),
    .o_cnt_trap     (o_cnt_trap)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic         pc_sel;
    logic [W-1:0] tgt;
    logic         fif, fid, fex, exc;
    logic [W-1:0] bad;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state: 0 idle, 1 redirect, 2 trap.
  int           m_st = 0;
  logic [W-1:0] m_tgt = '0;
  logic [W-1:0] m_bad = '0;
  logic [W-1:0] m_cb = '0, m_ct = '0, m_ctr = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, ":sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ":pc_sel"}, W'(o_pc_sel), W'(e.pc_sel));
    check({tag, ":pc_target"}, o_pc_target, e.tgt);
    check({tag, ":flush_if"}, W'(o_flush_if), W'(e.fif));
    check({tag, ":flush_id"}, W'(o_flush_id), W'(e.fid));
    check({tag, ":flush_ex"}, W'(o_flush_ex), W'(e.fex));
    check({tag, ":misalign"}, W'(o_misalign_exc), W'(e.exc));
    check({tag, ":bad_addr"}, o_bad_addr, e.bad);
  endtask

  task automatic push_zero_after_reset();
    exp_t e;
    m_st = 0; m_tgt = '0; m_bad = '0;
    m_cb = '0; m_ct = '0; m_ctr = '0;
    e = '0;
    sb_q.push_back(e);
  endtask

  // One clock of stimulus: drive, predict, advance an edge, compare.
  task automatic cycle(input string tag, input logic v, input logic br, input logic jp,
                       input logic cond, input logic [W-1:0] tgt, input logic stall,
                       input logic ack);
    exp_t e;
    logic take, misal;
    i_ex_valid = v; i_ex_branch = br; i_ex_jump = jp; i_ex_cond = cond;
    i_ex_target = tgt; i_stall = stall; i_trap_ack = ack;
    take  = v && !stall && (jp || (br && cond));
    misal = tgt[1] || tgt[0];
    e = '0;
    if (m_st == 0 && v && !stall) begin
      if (br || jp)        m_cb++;
      if (take && !misal)  m_ct++;
      if (take && misal)   m_ctr++;
    end
    if (m_st == 0) begin
      if (take && !misal) begin
        m_tgt = tgt; m_st = 1;
        e.pc_sel = 1'b1; e.fif = 1'b1; e.fid = 1'b1; e.fex = 1'b1;
      end else if (take) begin
        m_bad = tgt; m_st = 2;
        e.exc = 1'b1; e.fif = 1'b1; e.fid = 1'b1; e.fex = 1'b1;
      end
    end else if (m_st == 1) begin
      m_st = 0;
    end else begin
      if (ack) m_st = 0;
      else begin
        e.exc = 1'b1; e.fif = 1'b1; e.fid = 1'b1; e.fex = 1'b1;
      end
    end
    e.tgt = m_tgt;
    e.bad = m_bad;
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    compare_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_stall = 1'b0; i_ex_valid = 1'b0; i_ex_branch = 1'b0; i_ex_jump = 1'b0;
    i_ex_cond = 1'b0; i_ex_target = '0; i_trap_ack = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    push_zero_after_reset();
    compare_outputs("reset");
    i_rst = 1'b0;

    idle("idle0");
    // Taken BEQ to 0x100, then one clean cycle.
    cycle("beq_taken", 1, 1, 0, 1, 32'h0000_0100, 0, 0);
    idle("beq_after");
    // Not-taken branch, JAL 0x200, taken branch in the redirect cycle.
    cycle("bne_nt",    1, 1, 0, 0, 32'h0000_0300, 0, 0);
    cycle("jal_200",   1, 0, 1, 0, 32'h0000_0200, 0, 0);
    cycle("wrongpath", 1, 1, 0, 1, 32'h0000_0500, 0, 0);
    idle("jal_after");
    // JALR 0x404 held under stall for three cycles.
    for (int i = 0; i < 3; i++) cycle("jalr_stall", 1, 0, 1, 0, 32'h0000_0404, 1, 0);
    cycle("jalr_go",   1, 0, 1, 0, 32'h0000_0404, 0, 0);
    cycle("stall_in_redir", 1, 1, 0, 1, 32'h0000_0800, 1, 0);
    // Invalid EX with jump bits set must do nothing.
    cycle("invalid",   0, 0, 1, 1, 32'h0000_0900, 0, 0);
    // Misaligned JAL to 0x102, held 4 cycles, taken branch ignored in TRAP.
    cycle("jal_misal", 1, 0, 1, 0, 32'h0000_0102, 0, 0);
    for (int i = 0; i < 3; i++) idle("trap_hold");
    cycle("trap_ign",  1, 1, 0, 1, 32'h0000_0600, 0, 0);
    cycle("trap_ack",  0, 0, 0, 0, '0, 0, 1);
    cycle("ack_idle",  0, 0, 0, 0, '0, 0, 1);
    // Odd target traps too; ack arriving while stalled is still accepted.
    cycle("jal_odd",   1, 0, 1, 0, 32'h0000_0103, 0, 0);
    cycle("ack_stall", 0, 0, 0, 0, '0, 1, 1);
    // Non-taken branch with misaligned target: no trap.
    cycle("nt_misal",  1, 1, 0, 0, 32'h0000_0702, 0, 0);

`ifdef BRANCH_PERF_EN
    check("cnt_branch_mid", o_cnt_branch, m_cb);
    check("cnt_taken_mid", o_cnt_taken, m_ct);
    check("cnt_trap_mid", o_cnt_trap, m_ctr);
`endif

    // Reset asserted between edges while in TRAP.
    cycle("jal_misal2", 1, 0, 1, 0, 32'h0000_0206, 0, 0);
    idle("trap2_hold");
    #2;
    i_rst = 1'b1;
    #1;
    push_zero_after_reset();
    compare_outputs("async_rst");
    #1;
    i_rst = 1'b0;
    cycle("post_rst_br", 1, 1, 0, 1, 32'h0000_0040, 0, 0);
    idle("post_rst_after");

`ifdef BRANCH_PERF_EN
    // Five resolutions: 3 taken (one misaligned, acked), 2 not taken.
    cycle("p_b1", 1, 1, 0, 1, 32'h0000_1000, 0, 0);
    idle("p_i1");
    cycle("p_b2", 1, 1, 0, 0, 32'h0000_1004, 0, 0);
    cycle("p_b3", 1, 0, 1, 0, 32'h0000_2000, 0, 0);
    idle("p_i2");
    cycle("p_b4", 1, 1, 0, 0, 32'h0000_2008, 0, 0);
    cycle("p_b5", 1, 1, 0, 1, 32'h0000_300A, 0, 0);
    cycle("p_ack", 0, 0, 0, 0, '0, 0, 1);
    check("cnt_branch", o_cnt_branch, m_cb);
    check("cnt_taken", o_cnt_taken, m_ct);
    check("cnt_trap", o_cnt_trap, m_ctr);
    check("cnt_branch_abs", o_cnt_branch, 32'd6);
    check("cnt_taken_abs", o_cnt_taken, 32'd3);
    check("cnt_trap_abs", o_cnt_trap, 32'd1);
`endif

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences PC redirection for the pipelined RV32I core.
- Consumes the resolved branch/jump outcome and computed target from the EX-stage branch/jump target adder.
- Drives registered PC-select/target and flush signals to the IF, ID and EX stages.
- Raises an instruction-address-misaligned trap with an acknowledge handshake.
- Static not-taken fetch policy: every taken branch or jump costs one redirect cycle.

Parameters:
WIDTH, `WIDTH (32), datapath/PC width in bits.

Ports:
i_clk  input  1  core clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_stall  input  1  pipeline stall from hazard unit; EX contents frozen while high
i_ex_valid  input  1  EX holds a valid (non-bubble) instruction
i_ex_branch  input  1  EX instruction is a conditional branch
i_ex_jump  input  1  EX instruction is JAL or JALR
i_ex_cond  input  1  branch condition true (from ALU compare)
i_ex_target  input  WIDTH  computed next PC from the target adder
i_trap_ack  input  1  trap handler accepted misalign exception
o_pc_sel  output  1  select o_pc_target as next fetch PC
o_pc_target  output  WIDTH  redirect/trap target
o_flush_if  output  1  squash IF/ID register
o_flush_id  output  1  squash ID/EX register
o_flush_ex  output  1  squash EX/MEM register (wrong-path instruction in EX)
o_misalign_exc  output  1  instruction-address-misaligned trap pending
o_bad_addr  output  WIDTH  faulting target (mtval)

Behaviour:
- All outputs registered. Reset (async, i_rst=1): state IDLE, all outputs 0, o_pc_target=0, o_bad_addr=0.
- take = i_ex_valid & ~i_stall & (i_ex_jump | (i_ex_branch & i_ex_cond)).
- misal = i_ex_target[1] (bit0 already cleared by the target adder; an odd target is also misaligned, so bit0=1 is treated as misal).
- States: IDLE, REDIRECT, TRAP.
- IDLE:
  - take & ~misal -> REDIRECT. Latch o_pc_target=i_ex_target. Next cycle: o_pc_sel=1 and o_flush_if=o_flush_id=o_flush_ex=1.
  - take & misal -> TRAP. Latch o_bad_addr=i_ex_target. Next cycle: o_misalign_exc=1 and all three flushes=1. o_pc_sel stays 0.
  - Otherwise stay in IDLE, outputs 0.
- REDIRECT: lasts exactly one cycle, then -> IDLE.
  - Outputs drop to 0 at the following edge; o_pc_target holds its last value.
  - Any EX resolution in this cycle is wrong-path and is ignored, even if take=1.
  - i_stall does not extend REDIRECT; flush has priority over stall in the pipeline registers.
- TRAP: o_misalign_exc and all flushes held high until i_trap_ack=1.
  - Acknowledge sampled at the edge -> IDLE; outputs clear on that edge.
  - EX resolutions are ignored while in TRAP.
  - i_trap_ack in IDLE or REDIRECT has no effect.
- Latency: EX resolution at edge k -> redirect visible after edge k, i.e. one cycle. Net taken-branch penalty is two squashed instructions (ID and EX of the redirect cycle) plus IF.
- Stall: with i_stall=1, the EX instruction is not resolved; it is resolved on the first cycle i_stall=0.
- Non-taken branch or invalid EX: no action.
- Reset mid-REDIRECT or mid-TRAP: immediate return to IDLE, all outputs 0.

Optional Feature:
BRANCH_PERF_EN:
- Defined: adds outputs o_cnt_branch, o_cnt_taken, o_cnt_trap (each WIDTH), reset to 0.
  - Increment on accepted resolutions in IDLE only, and only when i_ex_valid & ~i_stall.
  - o_cnt_branch counts branches+jumps; o_cnt_taken counts redirects; o_cnt_trap counts traps.
  - Counters wrap modulo 2^WIDTH.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Taken BEQ: i_ex_valid=1, i_ex_branch=1, i_ex_cond=1, target=0x0000_0100 -> next cycle o_pc_sel=1, o_pc_target=0x100, three flushes=1; all 0 the cycle after.
- Not-taken branch then JAL to 0x200 in back-to-back cycles -> no action for the branch. JAL redirect appears one cycle later. A taken branch presented in the REDIRECT cycle is ignored (no second redirect).
- Stalled jump: JALR target 0x0000_0404 with i_stall=1 for 3 cycles -> no outputs during stall; redirect to 0x404 one cycle after i_stall falls.
- Misaligned: JAL target 0x0000_0102 -> o_misalign_exc=1, o_bad_addr=0x102, flushes held, o_pc_sel=0. Hold 4 cycles, assert i_trap_ack -> all clear next edge, state IDLE.
- Reset mid-TRAP: assert i_rst asynchronously between edges -> outputs 0 immediately. After release, a taken branch to 0x40 redirects normally.
- BRANCH_PERF_EN: 5 branches (3 taken, 1 misaligned and acked) -> o_cnt_branch=5, o_cnt_taken=2, o_cnt_trap=1.
